// File: rtl/replay_pkg.sv
// Shared sizing helpers and types for the replay capture path.
// Window length, spike-time width and the "no spike" code all derive from the replay buffer depth.
package replay_pkg;

   localparam int NUM_CONTEXTS       = 2;
   localparam int DEFAULT_BUF_DEPTH  = 16;

   function automatic int window_of(input int buffer_depth);
      return buffer_depth / 2;
   endfunction

   function automatic int tw_of(input int buffer_depth);
      return $clog2(buffer_depth / 2) + 1;
   endfunction

   // "No spike" is one past the last legal capture time, so it always loses the min search.
   function automatic int no_spike_of(input int buffer_depth);
      return buffer_depth / 2;
   endfunction

   localparam int DEFAULT_TW = tw_of(DEFAULT_BUF_DEPTH);

   typedef logic [DEFAULT_TW-1:0] spike_time_t;

endpackage

// File: rtl/replay_spike_capture_argmin.sv
// Combinational argmin over Q spike times: a balanced tree of pairwise compares.
// On equal times the lower neuron index wins, because the left operand is kept unless the right is strictly smaller.
module first_spike_argmin #(
   parameter int Q  = 16,
   parameter int TW = 4
) (
   input  logic [Q*TW-1:0]       times,
   output logic [TW-1:0]         min_time,
   output logic [$clog2(Q)-1:0]  min_idx
);

   localparam int IW     = $clog2(Q);
   localparam int LEVELS = IW;
   localparam int N      = 1 << LEVELS;

   logic [N*TW-1:0] base_t;
   logic [N*IW-1:0] base_i;

   // Pad to a power of two with all-ones times, which can never beat a real entry.
   always_comb begin
      base_t = '1;
      base_i = '0;
      for (int i = 0; i < Q; i++) begin
         base_t[i*TW +: TW] = times[i*TW +: TW];
         base_i[i*IW +: IW] = IW'(i);
      end
   end

   genvar lv;
   for (lv = 1; lv <= LEVELS; lv++) begin : g_lvl
      localparam int W = N >> lv;
      logic [2*W*TW-1:0] pt;
      logic [2*W*IW-1:0] px;
      logic [W*TW-1:0]   tv;
      logic [W*IW-1:0]   iv;

      if (lv == 1) begin : g_src
         assign pt = base_t;
         assign px = base_i;
      end else begin : g_src
         assign pt = g_lvl[lv-1].tv;
         assign px = g_lvl[lv-1].iv;
      end

      always_comb begin
         tv = '0;
         iv = '0;
         for (int i = 0; i < W; i++) begin
            if (pt[(2*i+1)*TW +: TW] < pt[(2*i)*TW +: TW]) begin
               tv[i*TW +: TW] = pt[(2*i+1)*TW +: TW];
               iv[i*IW +: IW] = px[(2*i+1)*IW +: IW];
            end else begin
               tv[i*TW +: TW] = pt[(2*i)*TW +: TW];
               iv[i*IW +: IW] = px[(2*i)*IW +: IW];
            end
         end
      end
   end

   assign min_time = g_lvl[LEVELS].tv;
   assign min_idx  = g_lvl[LEVELS].iv;

endmodule

// File: rtl/replay_spike_capture.sv
// Captures per-neuron first-spike times over each replayed context window and
// hands a time vector plus winner-take-all result to the readout through a one-deep valid/ready register.
module replay_spike_capture
   import replay_pkg::*;
#(
   parameter int Q            = 16,
   parameter int BUFFER_DEPTH = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start_count,
   input  logic                              ctx_sel,
   input  logic [Q-1:0]                      spike_in,
   input  logic                              out_ready,
   output logic                              out_valid,
   output logic                              out_ctx,
   output logic [Q*tw_of(BUFFER_DEPTH)-1:0]  out_times,
   output logic                              winner_valid,
   output logic [$clog2(Q)-1:0]              winner_idx,
   output logic                              overflow
);

   // Handshake: a result transfers on any edge where out_valid && out_ready.
   // out_* hold steady while out_valid=1 and out_ready=0; a commit arriving then is dropped and flagged in overflow.

   localparam int WINDOW = window_of(BUFFER_DEPTH);
   localparam int TW     = tw_of(BUFFER_DEPTH);
   localparam int IW     = $clog2(Q);
   localparam logic [TW-1:0] NO_SPIKE = TW'(no_spike_of(BUFFER_DEPTH));
   localparam logic [TW-1:0] LAST_T   = TW'(WINDOW - 1);

   logic [TW-1:0]   t;
   logic            ctx_q;
   logic [TW-1:0]   cap    [Q];
   logic [TW-1:0]   merged [Q];
   logic [TW-1:0]   fresh  [Q];
   logic [Q*TW-1:0] commit_times;

   logic toggle;
   logic in_window;
   logic commit_a;
   logic commit_b;
   logic commit;

   logic [TW-1:0] min_time;
   logic [IW-1:0] min_idx;
   logic          win_valid;
   logic [IW-1:0] win_idx;

   always_comb begin
      toggle    = (ctx_sel != ctx_q);
      in_window = (t < NO_SPIKE);
      commit_a  = start_count && !toggle && (t == LAST_T);
      // An early context switch commits whatever the old context caught so far.
      commit_b  = start_count && toggle && (t != '0) && in_window;
      commit    = commit_a || commit_b;
      commit_times = '0;
      for (int q = 0; q < Q; q++) begin
         merged[q] = (cap[q] == NO_SPIKE && spike_in[q] && in_window) ? t : cap[q];
         fresh[q]  = spike_in[q] ? '0 : NO_SPIKE;
         commit_times[q*TW +: TW] = commit_a ? merged[q] : cap[q];
      end
   end

   first_spike_argmin #(
      .Q  (Q),
      .TW (TW)
   ) u_argmin (
      .times    (commit_times),
      .min_time (min_time),
      .min_idx  (min_idx)
   );

   always_comb begin
      win_valid = (min_time != NO_SPIKE);
      win_idx   = win_valid ? min_idx : '0;
   end

   // Window counter and capture registers; the toggle cycle's spikes open the new window at t=0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         t     <= '0;
         ctx_q <= 1'b0;
         for (int q = 0; q < Q; q++) cap[q] <= NO_SPIKE;
      end else begin
         ctx_q <= ctx_sel;
         if (!start_count) begin
            t <= '0;
            for (int q = 0; q < Q; q++) cap[q] <= NO_SPIKE;
         end else if (toggle) begin
            t <= '0;
            for (int q = 0; q < Q; q++) cap[q] <= fresh[q];
         end else begin
            if (in_window) t <= t + TW'(1);
            for (int q = 0; q < Q; q++) cap[q] <= commit_a ? NO_SPIKE : merged[q];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_ctx      <= 1'b0;
         out_times    <= {Q{NO_SPIKE}};
         winner_valid <= 1'b0;
         winner_idx   <= '0;
         overflow     <= 1'b0;
      end else if (commit) begin
         if (!out_valid || out_ready) begin
            out_valid    <= 1'b1;
            out_ctx      <= ctx_q;
            out_times    <= commit_times;
            winner_valid <= win_valid;
            winner_idx   <= win_idx;
         end else begin
            overflow <= 1'b1;
         end
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_replay_spike_capture.sv
// Directed bench for replay_spike_capture with default sizing (Q=16, window 8, "no spike" = 8).
module tb_replay_spike_capture;

   localparam int Q  = 16;
   localparam int TW = 4;
   localparam logic [Q*TW-1:0] ALL_NONE = {Q{4'h8}};

   logic            clk;
   logic            rst;
   logic            start_count;
   logic            ctx_sel;
   logic [Q-1:0]    spike_in;
   logic            out_ready;
   logic            out_valid;
   logic            out_ctx;
   logic [Q*TW-1:0] out_times;
   logic            winner_valid;
   logic [3:0]      winner_idx;
   logic            overflow;

   int errors = 0;
   int checks = 0;
   logic [Q-1:0] win [16];

   replay_spike_capture #(.Q(16), .BUFFER_DEPTH(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_count  (start_count),
      .ctx_sel      (ctx_sel),
      .spike_in     (spike_in),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .out_ctx      (out_ctx),
      .out_times    (out_times),
      .winner_valid (winner_valid),
      .winner_idx   (winner_idx),
      .overflow     (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_win();
      for (int i = 0; i < 16; i++) win[i] = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         spike_in = win[i];
         step();
      end
      spike_in = '0;
   endtask

   // Expected time vector: all 8 except up to two listed neurons (index -1 skips).
   function automatic logic [Q*TW-1:0] tv(input int qa, input int ta, input int qb, input int tb);
      logic [Q*TW-1:0] v;
      v = ALL_NONE;
      if (qa >= 0) v[qa*TW +: TW] = TW'(ta);
      if (qb >= 0) v[qb*TW +: TW] = TW'(tb);
      return v;
   endfunction

   initial begin
      rst = 1'b1; start_count = 1'b0; ctx_sel = 1'b0; spike_in = '0; out_ready = 1'b1;
      clear_win();
      step(); step();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_times", out_times, ALL_NONE);
      chk("rst_wvalid", 64'(winner_valid), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      rst = 1'b0;
      step();

      // single spike, neuron 3 at t=2
      start_count = 1'b1;
      clear_win(); win[2][3] = 1'b1;
      run(7);
      chk("t1_not_yet", 64'(out_valid), 64'd0);
      run(1);
      chk("t1_valid", 64'(out_valid), 64'd1);
      chk("t1_times", out_times, tv(3, 2, -1, 0));
      chk("t1_wvalid", 64'(winner_valid), 64'd1);
      chk("t1_widx", 64'(winner_idx), 64'd3);
      chk("t1_ctx", 64'(out_ctx), 64'd0);
      start_count = 1'b0;
      step();
      chk("t1_consumed", 64'(out_valid), 64'd0);

      // repeat spike ignored, last-cycle spike included
      start_count = 1'b1;
      clear_win(); win[1][5] = 1'b1; win[4][5] = 1'b1; win[7][9] = 1'b1;
      run(8);
      chk("t2_times", out_times, tv(5, 1, 9, 7));
      chk("t2_widx", 64'(winner_idx), 64'd5);
      start_count = 1'b0;
      step();

      // tie goes to the lower index
      start_count = 1'b1;
      clear_win(); win[3][7] = 1'b1; win[3][2] = 1'b1;
      run(8);
      chk("t3_times", out_times, tv(7, 3, 2, 3));
      chk("t3_widx", 64'(winner_idx), 64'd2);
      start_count = 1'b0;
      step();
      start_count = 1'b1;
      clear_win();
      run(8);
      chk("t3_empty_valid", 64'(out_valid), 64'd1);
      chk("t3_empty_times", out_times, ALL_NONE);
      chk("t3_empty_wvalid", 64'(winner_valid), 64'd0);
      chk("t3_empty_widx", 64'(winner_idx), 64'd0);
      start_count = 1'b0;
      step();

      // backpressure across two windows
      out_ready = 1'b0;
      start_count = 1'b1;
      clear_win(); win[1][0] = 1'b1;
      run(8);
      chk("t4_first_valid", 64'(out_valid), 64'd1);
      chk("t4_no_ovf_yet", 64'(overflow), 64'd0);
      ctx_sel = 1'b1;
      clear_win(); win[3][6] = 1'b1;
      run(9);
      chk("t4_held_valid", 64'(out_valid), 64'd1);
      chk("t4_held_ctx", 64'(out_ctx), 64'd0);
      chk("t4_held_times", out_times, tv(0, 1, -1, 0));
      chk("t4_overflow", 64'(overflow), 64'd1);
      out_ready = 1'b1; start_count = 1'b0; ctx_sel = 1'b0;
      step();
      chk("t4_drained", 64'(out_valid), 64'd0);
      chk("t4_ovf_sticky", 64'(overflow), 64'd1);

      // early context switch at t=5
      start_count = 1'b1;
      clear_win(); win[2][1] = 1'b1;
      run(5);
      chk("t5_before_switch", 64'(out_valid), 64'd0);
      ctx_sel = 1'b1;
      clear_win(); win[0][4] = 1'b1;
      run(1);
      chk("t5_partial_valid", 64'(out_valid), 64'd1);
      chk("t5_partial_ctx", 64'(out_ctx), 64'd0);
      chk("t5_partial_times", out_times, tv(1, 2, -1, 0));
      chk("t5_partial_widx", 64'(winner_idx), 64'd1);
      clear_win();
      run(8);
      chk("t5_new_valid", 64'(out_valid), 64'd1);
      chk("t5_new_ctx", 64'(out_ctx), 64'd1);
      chk("t5_new_times", out_times, tv(4, 0, -1, 0));
      chk("t5_new_widx", 64'(winner_idx), 64'd4);
      start_count = 1'b0;
      step();

      // asynchronous reset mid-cycle with captures in flight
      start_count = 1'b1;
      clear_win(); win[1][2] = 1'b1;
      run(4);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_valid", 64'(out_valid), 64'd0);
      chk("t6_rst_times", out_times, ALL_NONE);
      chk("t6_rst_ctx", 64'(out_ctx), 64'd0);
      chk("t6_rst_wvalid", 64'(winner_valid), 64'd0);
      chk("t6_rst_widx", 64'(winner_idx), 64'd0);
      chk("t6_rst_overflow", 64'(overflow), 64'd0);
      ctx_sel = 1'b0;
      #1 rst = 1'b0;

      // start_count drop at t=3 discards the window and restarts t
      clear_win(); win[0][3] = 1'b1;
      run(3);
      start_count = 1'b0;
      step();
      chk("t6_drop_no_commit", 64'(out_valid), 64'd0);
      start_count = 1'b1;
      clear_win(); win[0][5] = 1'b1;
      run(7);
      chk("t6_restart_not_yet", 64'(out_valid), 64'd0);
      run(1);
      chk("t6_restart_valid", 64'(out_valid), 64'd1);
      chk("t6_restart_times", out_times, tv(5, 0, -1, 0));
      chk("t6_restart_widx", 64'(winner_idx), 64'd5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/replay_spike_capture.md
Name: replay_spike_capture

Overview:
- Downstream neighbour of the two-context replay buffer: consumes the column's output spike vector while the two input contexts are replayed one after another.
- Converts each context's replay window into a per-neuron first-spike-time vector plus a winner-take-all result.
- Hands the result to the readout stage through a valid/ready register.
- Number of contexts is fixed at 2; the active context is identified by ctx_sel, which is the same signal that drives the replay mux select.

Parameters:
- Q, 16: number of column output neurons (width of spike_in).
- BUFFER_DEPTH, 16: replay buffer depth. localparam WINDOW = BUFFER_DEPTH/2 is the number of capture cycles per context.
- localparam TW = $clog2(WINDOW)+1: spike-time width. localparam NO_SPIKE = WINDOW, the encoding for "no spike" (8 with defaults).

Ports:
- clk  in  1  sole clock, posedge.
- rst  in  1  asynchronous, active-high reset.
- start_count  in  1  replay active, same signal that drives the replay buffer counters.
- ctx_sel  in  1  context currently being replayed (0/1).
- spike_in  in  Q  column output spikes for this cycle.
- out_ready  in  1  consumer accepts the result.
- out_valid  out  1  result register holds an unconsumed result.
- out_ctx  out  1  context the result belongs to.
- out_times  out  Q*TW  neuron q's time in bits [q*TW +: TW].
- winner_valid  out  1  at least one neuron spiked in the window.
- winner_idx  out  $clog2(Q)  earliest-spiking neuron.
- overflow  out  1  sticky: a result was dropped under backpressure.

Behaviour:
- Reset (async, any time): t=0; ctx_q=0; all capture regs=NO_SPIKE; out_valid=0; out_ctx=0; out_times all NO_SPIKE; winner_valid=0; winner_idx=0; overflow=0. No commit is issued for the interrupted window.
- Window counter t (TW bits):
  - start_count=0: t<=0, capture regs<=NO_SPIKE, and the window is discarded without a commit.
  - Toggle detected (ctx_sel!=ctx_q): t<=0; ctx_q<=ctx_sel.
  - Otherwise, while t<WINDOW: t<=t+1. t saturates at WINDOW.
- Capture: in a cycle with start_count=1, no toggle and t<WINDOW, each q with cap[q]==NO_SPIKE and spike_in[q]=1 gets cap[q]<=t. The first spike wins; later spikes in the same window are ignored.
- Commit event, either of:
  - (a) start_count=1, no toggle, t==WINDOW-1. The commit includes that cycle's spikes.
  - (b) Toggle while start_count=1 and 0<t<WINDOW (early context switch). This is a partial commit of ctx_q; uncaptured neurons stay NO_SPIKE. spike_in in the toggle cycle belongs to the new window and is captured at t=0.
- After a commit, cap is cleared to NO_SPIKE in the same edge. Case (a) spikes arriving at t==WINDOW are ignored until the next toggle.
- Commit data:
  - times = merged cap, including the current cycle for (a).
  - winner = minimum time over q, ties broken by lowest index.
  - winner_valid = (min != NO_SPIKE); winner_idx=0 when winner_valid=0.
  - ctx = ctx_q.
- Output register, one-deep:
  - On commit, if out_valid=0 or out_ready=1: load all out_* and set out_valid=1. The result is visible on the cycle after the last capture cycle (1-cycle latency).
  - On commit with out_valid=1 and out_ready=0: drop the new result, keep the old one, set overflow<=1.
  - No commit and out_valid&out_ready: out_valid<=0; data holds its last value.
- overflow clears only on rst.
- Width rules: t never exceeds WINDOW; time comparisons are unsigned TW-bit.

Decomposition:
- Package replay_pkg: WINDOW/TW/NO_SPIKE derivation functions, NUM_CONTEXTS=2, typedef spike_time_t (logic [TW-1:0]).
- Sub-module first_spike_argmin (purely combinational, parameter Q/TW): Q times in, min_time and min_idx out, lowest-index tie-break, log2(Q)-level tree.

Test Plan:
1. Defaults, ctx_sel=0, start_count=1 for 8 cycles; spike_in[3]=1 only at t=2 -> out_valid high at cycle t=8; out_times[3]=2, all others 8; winner_valid=1, winner_idx=3, out_ctx=0.
2. Neuron 5 spikes at t=1 and t=4; neuron 9 spikes at t=7 (last cycle) -> times[5]=1, times[9]=7, winner_idx=5.
3. Tie: neurons 7 and 2 both spike at t=3, nothing earlier -> winner_idx=2; zero spikes in the next window -> all times 8, winner_valid=0, winner_idx=0.
4. Backpressure: out_ready=0 through two full windows (ctx 0 then 1) -> first result held with out_ctx=0, overflow=1. Then out_ready=1 for one cycle -> out_valid falls.
5. Early switch: ctx_sel toggles at t=5 with neuron 1 at t=2, and neuron 4 spikes in the toggle cycle -> commit ctx0 with times[1]=2, rest 8. In the new ctx1 window, cap[4]=0.
6. rst pulsed asynchronously mid-cycle at t=4 with captured spikes -> all outputs zero/NO_SPIKE immediately, no out_valid. start_count drop at t=3 -> no commit and t=0.
